// File: rtl/noc_link_pkg.sv
// noc_link_pkg: shared flit type and width helpers for the NoC link blocks.
package noc_link_pkg;

    localparam int FLIT_W = 128;
    localparam int DEST_W = 6;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              is_tail;
    } flit_t;

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: synchronous flit FIFO with fill count; head is read from storage,
// so a flit written at an edge is visible at the head only from the next cycle.
module noc_flit_fifo import noc_link_pkg::*; #(
    parameter int WIDTH     = FLIT_W + DEST_W + 1,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = occ_width(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    output logic [WIDTH-1:0]     o_rd_data,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_wr;
    logic                 w_rd;

    assign o_full    = r_count == CNT_WIDTH'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_WIDTH'(w_wr) - CNT_WIDTH'(w_rd);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/noc_credit_relay.sv
// noc_credit_relay: credit-based link relay; buffers upstream flits, forwards them
// under a downstream credit counter and returns one upstream credit per flit forwarded.
module noc_credit_relay import noc_link_pkg::*; #(
    parameter int FLIT_WIDTH         = 128,
    parameter int DEST_WIDTH         = 6,
    parameter int BUFFER_DEPTH       = 8,
    parameter int DOWNSTREAM_CREDITS = 8,
    parameter int CREDIT_WIDTH       = credit_width(DOWNSTREAM_CREDITS),
    parameter int OCC_WIDTH          = occ_width(BUFFER_DEPTH)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]   data_in,
    input  logic [DEST_WIDTH-1:0]   dest_in,
    input  logic                    is_tail_in,
    input  logic                    send_in,
    output logic                    credit_out,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [OCC_WIDTH-1:0]    occupancy,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    overflow_err,
    output logic                    credit_err
);

    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;

    logic [ENTRY_W-1:0]      w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic [FLIT_WIDTH-1:0]   r_data;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic                    r_tail;
    logic                    r_send;
    logic                    r_credit_out;
    logic                    r_overflow_err;
    logic                    r_credit_err;

    assign w_pop = !w_empty && r_credit != '0;

    noc_flit_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (BUFFER_DEPTH),
        .CNT_WIDTH (OCC_WIDTH)
    ) u_fifo (
        .i_clk     (clk_noc),
        .i_rst     (rst_noc_sync),
        .i_wr_en   (send_in),
        .i_wr_data ({data_in, dest_in, is_tail_in}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (occupancy),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_credit       <= CREDIT_WIDTH'(DOWNSTREAM_CREDITS);
            r_data         <= '0;
            r_dest         <= '0;
            r_tail         <= 1'b0;
            r_send         <= 1'b0;
            r_credit_out   <= 1'b0;
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
        end else begin
            r_send       <= w_pop;
            r_credit_out <= w_pop;
            if (w_pop) {r_data, r_dest, r_tail} <= w_head;
            // pop and credit_in together cancel out
            if (w_pop && !credit_in) begin
                r_credit <= r_credit - 1'b1;
            end else if (credit_in && !w_pop) begin
                if (r_credit == CREDIT_WIDTH'(DOWNSTREAM_CREDITS)) r_credit_err <= 1'b1;
                else r_credit <= r_credit + 1'b1;
            end
            if (send_in && w_full) r_overflow_err <= 1'b1;
        end
    end

    assign data_out     = r_data;
    assign dest_out     = r_dest;
    assign is_tail_out  = r_tail;
    assign send_out     = r_send;
    assign credit_out   = r_credit_out;
    assign credit_count = r_credit;
    assign overflow_err = r_overflow_err;
    assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_noc_credit_relay.sv
// tb_noc_credit_relay: directed and randomised scoreboard bench for noc_credit_relay.
module tb_noc_credit_relay;
    import noc_link_pkg::*;

    logic         clk_noc = 1'b0;
    logic         rst_noc_sync = 1'b1;
    logic [127:0] data_in = '0;
    logic [5:0]   dest_in = '0;
    logic         is_tail_in = 1'b0;
    logic         send_in = 1'b0;
    logic         credit_out;
    logic [127:0] data_out;
    logic [5:0]   dest_out;
    logic         is_tail_out;
    logic         send_out;
    logic         credit_in = 1'b0;
    logic [3:0]   occupancy;
    logic [3:0]   credit_count;
    logic         overflow_err;
    logic         credit_err;

    int checks = 0;
    int passed = 0;
    int n_send = 0;
    int n_cr = 0;
    flit_t q_out[$];
    flit_t q_in[$];

    noc_credit_relay dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .data_out     (data_out),
        .dest_out     (dest_out),
        .is_tail_out  (is_tail_out),
        .send_out     (send_out),
        .credit_in    (credit_in),
        .occupancy    (occupancy),
        .credit_count (credit_count),
        .overflow_err (overflow_err),
        .credit_err   (credit_err)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic cyc();
        @(posedge clk_noc);
        #1;
        if (send_out) begin
            n_send++;
            q_out.push_back({data_out, dest_out, is_tail_out});
        end
        if (credit_out) n_cr++;
    endtask

    task automatic clear_obs();
        n_send = 0;
        n_cr = 0;
        q_out.delete();
    endtask

    task automatic do_reset();
        send_in = 1'b0;
        credit_in = 1'b0;
        rst_noc_sync = 1'b1;
        cyc();
        cyc();
        rst_noc_sync = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else passed++;
        checks++; if (credit_count !== 4'd8) $display("FAIL reset_credit: got %0d want 8", credit_count); else passed++;
        checks++; if ({send_out, credit_out, is_tail_out} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {send_out, credit_out, is_tail_out}); else passed++;
        checks++; if ({data_out, dest_out} !== '0) $display("FAIL reset_data: got %h/%h want 0", data_out, dest_out); else passed++;
        checks++; if ({overflow_err, credit_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {overflow_err, credit_err}); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        send_in = 1'b1; data_in = 128'hA5; dest_in = 6'd3; is_tail_in = 1'b1;
        cyc();
        send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        checks++; if ({send_out, occupancy} !== {1'b0, 4'd1}) $display("FAIL single_pop_cycle: got send=%b occ=%0d want send=0 occ=1", send_out, occupancy); else passed++;
        cyc();
        checks++; if ({send_out, credit_out} !== 2'b11) $display("FAIL single_send: got send=%b credit=%b want 1 1", send_out, credit_out); else passed++;
        checks++; if ({data_out, dest_out, is_tail_out} !== {128'hA5, 6'd3, 1'b1}) $display("FAIL single_fields: got %h/%0d/%b want a5/3/1", data_out, dest_out, is_tail_out); else passed++;
        checks++; if (credit_count !== 4'd7) $display("FAIL single_cc7: got %0d want 7", credit_count); else passed++;
        cyc();
        checks++; if ({send_out, credit_out} !== 2'b00) $display("FAIL single_one_pulse: got send=%b credit=%b want 0 0", send_out, credit_out); else passed++;
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        checks++; if (credit_count !== 4'd8) $display("FAIL single_cc8: got %0d want 8", credit_count); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_in = 1'b1;
            data_in = (i < 8) ? 128'(32'h100 + i) : 128'(32'h200 + i - 8);
            dest_in = 6'(i);
            is_tail_in = (i % 4) == 3;
            cyc();
        end
        send_in = 1'b0;
        repeat (4) cyc();
        checks++; if (n_send !== 8) $display("FAIL burst_sends: got %0d want 8", n_send); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_out.size() != 8 || q_out[i].data !== 128'(32'h100 + i) || q_out[i].dest !== 6'(i))
                $display("FAIL burst_order[%0d]: got %h want %h", i, (q_out.size() > i) ? q_out[i].data : 128'hx, 32'h100 + i);
            else passed++;
        end
        checks++; if (n_cr !== 8) $display("FAIL burst_credits: got %0d want 8", n_cr); else passed++;
        checks++; if (occupancy !== 4'd8) $display("FAIL burst_occ: got %0d want 8", occupancy); else passed++;
        checks++; if (credit_count !== 4'd0) $display("FAIL burst_cc: got %0d want 0", credit_count); else passed++;
        checks++; if ({send_out, overflow_err} !== 2'b00) $display("FAIL burst_idle: got send=%b ovf=%b want 0 0", send_out, overflow_err); else passed++;
    endtask

    task automatic test_overflow();
        clear_obs();
        send_in = 1'b1; data_in = 128'h300;
        cyc();
        send_in = 1'b0; data_in = '0;
        checks++; if (overflow_err !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_err); else passed++;
        checks++; if (occupancy !== 4'd8) $display("FAIL ovf_occ: got %0d want 8", occupancy); else passed++;
        credit_in = 1'b1;
        repeat (3) cyc();
        credit_in = 1'b0;
        repeat (5) cyc();
        checks++; if (n_send !== 3) $display("FAIL ovf_sends: got %0d want 3", n_send); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_out.size() != 3 || q_out[i].data !== 128'(32'h200 + i))
                $display("FAIL ovf_order[%0d]: got %h want %h", i, (q_out.size() > i) ? q_out[i].data : 128'hx, 32'h200 + i);
            else passed++;
        end
        checks++; if (n_cr !== 3) $display("FAIL ovf_credits: got %0d want 3", n_cr); else passed++;
        checks++; if ({occupancy, credit_count} !== {4'd5, 4'd0}) $display("FAIL ovf_state: got occ=%0d cc=%0d want 5 0", occupancy, credit_count); else passed++;
    endtask

    task automatic test_reset_mid();
        checks++; if (occupancy !== 4'd5) $display("FAIL mid_pre_occ: got %0d want 5", occupancy); else passed++;
        rst_noc_sync = 1'b1;
        cyc();
        rst_noc_sync = 1'b0;
        checks++; if ({occupancy, credit_count} !== {4'd0, 4'd8}) $display("FAIL mid_state: got occ=%0d cc=%0d want 0 8", occupancy, credit_count); else passed++;
        checks++; if ({send_out, credit_out, overflow_err} !== 3'b000) $display("FAIL mid_ctl: got %b want 000", {send_out, credit_out, overflow_err}); else passed++;
        clear_obs();
        repeat (4) cyc();
        checks++; if ({n_send, n_cr} !== {32'd0, 32'd0}) $display("FAIL mid_quiet: got sends=%0d credits=%0d want 0 0", n_send, n_cr); else passed++;
    endtask

    task automatic test_credit();
        do_reset();
        send_in = 1'b1;
        repeat (4) cyc();
        send_in = 1'b0;
        repeat (4) cyc();
        checks++; if ({credit_count, occupancy} !== {4'd4, 4'd0}) $display("FAIL cr_setup: got cc=%0d occ=%0d want 4 0", credit_count, occupancy); else passed++;
        send_in = 1'b1;
        cyc();
        send_in = 1'b0;
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        checks++; if ({credit_count, send_out} !== {4'd4, 1'b1}) $display("FAIL cr_both: got cc=%0d send=%b want 4 1", credit_count, send_out); else passed++;
        credit_in = 1'b1;
        repeat (4) cyc();
        credit_in = 1'b0;
        checks++; if ({credit_count, credit_err} !== {4'd8, 1'b0}) $display("FAIL cr_full: got cc=%0d err=%b want 8 0", credit_count, credit_err); else passed++;
        credit_in = 1'b1;
        cyc();
        credit_in = 1'b0;
        checks++; if ({credit_count, credit_err} !== {4'd8, 1'b1}) $display("FAIL cr_sat: got cc=%0d err=%b want 8 1", credit_count, credit_err); else passed++;
        cyc();
        checks++; if (credit_err !== 1'b1) $display("FAIL cr_sticky: got %b want 1", credit_err); else passed++;
        rst_noc_sync = 1'b1;
        cyc();
        rst_noc_sync = 1'b0;
        checks++; if (credit_err !== 1'b0) $display("FAIL cr_clear: got %b want 0", credit_err); else passed++;
    endtask

    task automatic test_random();
        int up_cred = 8;
        int ds_cnt = 0;
        int ds_ovf = 0;
        int bad = 0;
        flit_t f;
        do_reset();
        q_in.delete();
        for (int i = 0; i < 10000; i++) begin
            cyc();
            if (send_out) begin
                ds_cnt++;
                if (ds_cnt > 8) ds_ovf++;
            end
            if (credit_out) up_cred++;
            while (q_out.size() > 0) begin
                f = q_out.pop_front();
                if (q_in.size() == 0 || f !== q_in[0]) begin
                    if (bad < 10) $display("FAIL rand_flit: got %h want %h", f, (q_in.size() > 0) ? q_in[0] : 'x);
                    bad++;
                end
                if (q_in.size() > 0) void'(q_in.pop_front());
            end
            credit_in = ds_cnt > 0 && $urandom_range(0, 2) == 0;
            if (credit_in) ds_cnt--;
            send_in = up_cred > 0 && i < 9800 && $urandom_range(0, 3) != 0;
            if (send_in) begin
                f = {$urandom, $urandom, $urandom, $urandom, 6'($urandom), 1'($urandom)};
                {data_in, dest_in, is_tail_in} = f;
                up_cred--;
                q_in.push_back(f);
            end
        end
        send_in = 1'b0;
        credit_in = 1'b0;
        checks++; if (bad !== 0) $display("FAIL rand_order: got %0d bad flits want 0", bad); else passed++;
        checks++; if (q_in.size() !== 0) $display("FAIL rand_drain: got %0d pending want 0", q_in.size()); else passed++;
        checks++; if (n_cr !== n_send || n_send < 1000) $display("FAIL rand_credit_balance: got credits=%0d sends=%0d want equal and >=1000", n_cr, n_send); else passed++;
        checks++; if (ds_ovf !== 0) $display("FAIL rand_ds_credit: got %0d overruns want 0", ds_ovf); else passed++;
        checks++; if ({overflow_err, credit_err} !== 2'b00) $display("FAIL rand_err: got %b want 00", {overflow_err, credit_err}); else passed++;
        checks++; if (up_cred !== 8) $display("FAIL rand_up_cred: got %0d want 8", up_cred); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_credit();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
